// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake and a memory timeout watchdog.
// Define MULTICYCLE_CTRL_JAL_EN to decode JAL (opcode 0x03) as a jump that links into $31.
module multicycle_control #(
   parameter int OP_WIDTH    = 6,
   parameter int ALUOP_WIDTH = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [OP_WIDTH-1:0]    OP,
   input  logic                   mem_ready,
   output logic                   PCWrite,
   output logic                   PCWriteCondEQ,
   output logic                   PCWriteCondNE,
   output logic                   IorD,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   MemtoReg,
   output logic                   RegDst,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic                   jal_link,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             PCSource,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic                   illegal_op,
   output logic                   mem_timeout,
   output logic [3:0]             state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_WB_R      = 4'd3,
      S_EXEC_I    = 4'd4,
      S_WB_I      = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WB    = 4'd8,
      S_MEM_WRITE = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11
   } state_t;

   localparam logic [OP_WIDTH-1:0] OPC_R    = OP_WIDTH'(6'h00);
   localparam logic [OP_WIDTH-1:0] OPC_J    = OP_WIDTH'(6'h02);
   localparam logic [OP_WIDTH-1:0] OPC_BEQ  = OP_WIDTH'(6'h04);
   localparam logic [OP_WIDTH-1:0] OPC_BNE  = OP_WIDTH'(6'h05);
   localparam logic [OP_WIDTH-1:0] OPC_ADDI = OP_WIDTH'(6'h08);
   localparam logic [OP_WIDTH-1:0] OPC_ANDI = OP_WIDTH'(6'h0C);
   localparam logic [OP_WIDTH-1:0] OPC_ORI  = OP_WIDTH'(6'h0D);
   localparam logic [OP_WIDTH-1:0] OPC_LUI  = OP_WIDTH'(6'h0F);
   localparam logic [OP_WIDTH-1:0] OPC_LW   = OP_WIDTH'(6'h23);
   localparam logic [OP_WIDTH-1:0] OPC_SW   = OP_WIDTH'(6'h2B);
`ifdef MULTICYCLE_CTRL_JAL_EN
   localparam logic [OP_WIDTH-1:0] OPC_JAL  = OP_WIDTH'(6'h03);
`endif

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(3'b000);
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = ALUOP_WIDTH'(3'b001);
   localparam logic [ALUOP_WIDTH-1:0] ALU_FUNC = ALUOP_WIDTH'(3'b010);
   localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = ALUOP_WIDTH'(3'b011);
   localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = ALUOP_WIDTH'(3'b100);
   localparam logic [ALUOP_WIDTH-1:0] ALU_LUI  = ALUOP_WIDTH'(3'b101);

   localparam bit WDOG_EN = (MEM_TIMEOUT > 0);
   localparam int CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = WDOG_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

   state_t              state_q, state_d;
   logic [OP_WIDTH-1:0] op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                timeout;
   logic                decode_illegal;
   logic                wait_state;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      cnt_d          = '0;
      timeout        = 1'b0;
      decode_illegal = 1'b0;
      wait_state     = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

      // Only consecutive not-ready cycles in a waiting state count; mem_ready at the limit wins.
      if (WDOG_EN && wait_state && !mem_ready) begin
         if (cnt_q == CNT_LIMIT) begin
            timeout = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = OP;
            case (OP)
               OPC_R:                                 state_d = S_EXEC_R;
               OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_LUI:  state_d = S_EXEC_I;
               OPC_LW, OPC_SW:                        state_d = S_MEM_ADDR;
               OPC_BEQ, OPC_BNE:                      state_d = S_BRANCH;
               OPC_J:                                 state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
               OPC_JAL:                               state_d = S_JUMP;
`endif
               default: begin
                  state_d        = S_FETCH;
                  decode_illegal = 1'b1;
               end
            endcase
         end
         S_EXEC_R:    state_d = S_WB_R;
         S_EXEC_I:    state_d = S_WB_I;
         S_MEM_ADDR:  state_d = (op_q == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase

      if (timeout) state_d = S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   // Everything, including the debug state, reads as zero while reset is held low.
   always_comb begin
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      jal_link      = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      ALUOp         = ALU_ADD;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
      state         = 4'd0;
      if (reset) begin
         state       = state_q;
         mem_timeout = timeout;
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: begin
               ALUSrcB    = 2'b11;
               illegal_op = decode_illegal;
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALU_FUNC;
            end
            S_WB_R: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               case (op_q)
                  OPC_ORI:  ALUOp = ALU_OR;
                  OPC_ANDI: ALUOp = ALU_AND;
                  OPC_LUI:  ALUOp = ALU_LUI;
                  default:  ALUOp = ALU_ADD;
               endcase
            end
            S_WB_I:     RegWrite = 1'b1;
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
               MemWrite = ~timeout;
               IorD     = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA       = 1'b1;
               ALUOp         = ALU_SUB;
               PCSource      = 2'b01;
               PCWriteCondEQ = (op_q == OPC_BEQ);
               PCWriteCondNE = (op_q == OPC_BNE);
            end
            S_JUMP: begin
               PCSource = 2'b10;
               PCWrite  = 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
               if (op_q == OPC_JAL) begin
                  RegWrite = 1'b1;
                  jal_link = 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
